// File: rtl/sba_interconnect.sv
// sba_interconnect: single-master, NS-slave SBA router. It decodes addresses through a base/mask window table and registers the response.
// Optional feature macro SBA_TIMEOUT_EN: a slave that stays silent in BUSY for TIMEOUT cycles completes with o_err.
module sba_interconnect #(
  parameter int NS = 6,
  parameter logic [NS*32-1:0] SLAVE_BASE = {32'h10001000, 32'h10000000, 32'h0C000000,
                                            32'h02000000, 32'h80000000, 32'h00000000},
  parameter logic [NS*32-1:0] SLAVE_MASK = {32'hFFFFF000, 32'hFFFFF000, 32'hFF000000,
                                            32'hFF000000, 32'hFF000000, 32'hFF000000},
  parameter int TIMEOUT = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stb,
  input  logic [3:0]       i_we,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_dat_w,
  output logic [31:0]      o_dat_r,
  output logic             o_ack,
  output logic             o_err,
  output logic [NS-1:0]    o_s_stb,
  output logic [3:0]       o_s_we,
  output logic [31:0]      o_s_addr,
  output logic [31:0]      o_s_dat_w,
  input  logic [NS*32-1:0] i_s_dat_r,
  input  logic [NS-1:0]    i_s_ack
);

  // Handshake: the master holds i_stb and all request fields until o_ack or o_err.
  // Each slave sees its o_s_stb bit held high until it acks. A one-cycle ack from the selected slave completes the transfer.
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          err_q, err_d;
  logic [31:0]   dat_r_q, dat_r_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   dat_w_q, dat_w_d;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          ack_sel;
  logic [31:0]   dat_sel;

  // Walk from the top index down so the lowest matching window wins on overlap.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((i_addr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
        hit     = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    for (int k = 0; k < NS; k++) begin
      if (sel_q == SW'(k)) begin
        ack_sel = i_s_ack[k];
        dat_sel = i_s_dat_r[32*k +: 32];
      end
    end
  end

`ifdef SBA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          expired;

  // Expiry is judged on the incremented value, so the strobe is held for exactly TIMEOUT cycles.
  assign cnt_inc = cnt_q + CW'(1);
  assign expired = (cnt_inc == CW'(TIMEOUT));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    dat_r_d = dat_r_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dat_w_d = dat_w_q;
`ifdef SBA_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_stb) begin
          we_d    = i_we;
          addr_d  = i_addr;
          dat_w_d = i_dat_w;
          if (hit) begin
            sel_d   = hit_idx;
            state_d = BUSY;
`ifdef SBA_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d   = 1'b1;
            dat_r_d = '0;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (ack_sel) begin
          err_d   = 1'b0;
          dat_r_d = dat_sel;
          state_d = RESP;
        end
`ifdef SBA_TIMEOUT_EN
        else if (expired) begin
          err_d   = 1'b1;
          dat_r_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      dat_w_q <= '0;
`ifdef SBA_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      dat_r_q <= dat_r_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dat_w_q <= dat_w_d;
`ifdef SBA_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // The strobe follows the state, so it drops the cycle after the ack, the timeout or the reset.
  always_comb begin
    o_s_stb = '0;
    for (int k = 0; k < NS; k++) begin
      o_s_stb[k] = (state_q == BUSY) && (sel_q == SW'(k));
    end
  end

  assign o_ack     = (state_q == RESP) && !err_q;
  assign o_err     = (state_q == RESP) && err_q;
  assign o_dat_r   = dat_r_q;
  assign o_s_we    = we_q;
  assign o_s_addr  = addr_q;
  assign o_s_dat_w = dat_w_q;

endmodule
